// File: rtl/sequential_divider_if.sv
// sequential_divider_if: handshake and data bundle for the iterative signed divider.
//   start, in1, in2       : request and operands, driven by the requester (master)
//   quotient, remainder   : registered results, valid from the cycle done is high
//   busy, done            : operation-in-progress level and one-cycle completion pulse
//   div_by_zero, overflow : status flags of the last completed operation
interface sequential_divider_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [WIDTH-1:0] in1;
  logic [WIDTH-1:0] in2;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             busy;
  logic             done;
  logic             div_by_zero;
  logic             overflow;

  modport master (
    output start, in1, in2,
    input  quotient, remainder, busy, done, div_by_zero, overflow
  );

  modport slave (
    input  start, in1, in2,
    output quotient, remainder, busy, done, div_by_zero, overflow
  );
endinterface

// File: rtl/sequential_divider.sv
// sequential_divider: iterative signed restoring divider, one quotient bit per clock.
//   clk : rising-edge clock
//   rst : synchronous active-high reset; aborts any operation in flight
//   bus : sequential_divider_if slave port
//         start (sampled only in IDLE), in1 = dividend, in2 = divisor,
//         quotient (truncated toward zero), remainder (sign of dividend),
//         busy, done (one-cycle pulse), div_by_zero, overflow.
// Latency: WIDTH+1 edges after the accepting edge; divide by zero takes 1 edge.
// Results and flags hold until the next completed operation or reset.
module sequential_divider #(
  parameter int WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  sequential_divider_if.slave  bus
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, RUN, FINISH} state_t;

  state_t           state_reg;
  logic [WIDTH-1:0] dividend_reg;   // shifts out dividend bits, shifts in quotient bits
  logic [WIDTH-1:0] divisor_reg;
  logic [WIDTH:0]   prem_reg;       // partial remainder
  logic [CW-1:0]    count_reg;
  logic             sign_q_reg;
  logic             sign_r_reg;
  logic             dbz_pending_reg;
  logic             ovf_pending_reg;

  logic [WIDTH-1:0] quotient_reg;
  logic [WIDTH-1:0] remainder_reg;
  logic             busy_reg;
  logic             done_reg;
  logic             div_by_zero_reg;
  logic             overflow_reg;

  logic [WIDTH-1:0] in1_abs;
  logic [WIDTH-1:0] in2_abs;
  logic [WIDTH+1:0] trial;
  logic             in1_most_neg;
  logic             in2_minus_one;

  always_comb begin
    // Negating the most-negative value wraps to itself, which read as
    // unsigned is exactly its magnitude 2^(WIDTH-1).
    in1_abs       = bus.in1[WIDTH-1] ? -bus.in1 : bus.in1;
    in2_abs       = bus.in2[WIDTH-1] ? -bus.in2 : bus.in2;
    in1_most_neg  = (bus.in1 == {1'b1, {(WIDTH-1){1'b0}}});
    in2_minus_one = (bus.in2 == {WIDTH{1'b1}});
    // Shifted partial remainder minus divisor, one bit wider so the sign bit
    // can never be lost; a set MSB means the trial went negative.
    trial = {prem_reg, dividend_reg[WIDTH-1]} - {2'b00, divisor_reg};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg       <= IDLE;
      dividend_reg    <= '0;
      divisor_reg     <= '0;
      prem_reg        <= '0;
      count_reg       <= '0;
      sign_q_reg      <= 1'b0;
      sign_r_reg      <= 1'b0;
      dbz_pending_reg <= 1'b0;
      ovf_pending_reg <= 1'b0;
      quotient_reg    <= '0;
      remainder_reg   <= '0;
      busy_reg        <= 1'b0;
      done_reg        <= 1'b0;
      div_by_zero_reg <= 1'b0;
      overflow_reg    <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (bus.start) begin
            divisor_reg     <= in2_abs;
            prem_reg        <= '0;
            count_reg       <= '0;
            sign_q_reg      <= bus.in1[WIDTH-1] ^ bus.in2[WIDTH-1];
            sign_r_reg      <= bus.in1[WIDTH-1];
            ovf_pending_reg <= in1_most_neg && in2_minus_one;
            busy_reg        <= 1'b1;
            if (bus.in2 == '0) begin
              // The dividend register is idle on this path, so it carries the
              // raw dividend through to become the remainder.
              dividend_reg    <= bus.in1;
              dbz_pending_reg <= 1'b1;
              state_reg       <= FINISH;
            end else begin
              dividend_reg    <= in1_abs;
              dbz_pending_reg <= 1'b0;
              state_reg       <= RUN;
            end
          end
        end

        RUN: begin
          if (!trial[WIDTH+1]) begin
            prem_reg     <= trial[WIDTH:0];
            dividend_reg <= {dividend_reg[WIDTH-2:0], 1'b1};
          end else begin
            prem_reg     <= {prem_reg[WIDTH-1:0], dividend_reg[WIDTH-1]};
            dividend_reg <= {dividend_reg[WIDTH-2:0], 1'b0};
          end
          count_reg <= count_reg + 1'b1;
          if (count_reg == CW'(WIDTH - 1)) begin
            state_reg <= FINISH;
          end
        end

        FINISH: begin
          if (dbz_pending_reg) begin
            quotient_reg  <= '1;
            remainder_reg <= dividend_reg;
          end else begin
            quotient_reg  <= sign_q_reg ? -dividend_reg : dividend_reg;
            remainder_reg <= sign_r_reg ? -prem_reg[WIDTH-1:0] : prem_reg[WIDTH-1:0];
          end
          div_by_zero_reg <= dbz_pending_reg;
          overflow_reg    <= ovf_pending_reg;
          done_reg        <= 1'b1;
          busy_reg        <= 1'b0;
          state_reg       <= IDLE;
        end

        default: begin
          state_reg <= IDLE;
          busy_reg  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.quotient    = quotient_reg;
  assign bus.remainder   = remainder_reg;
  assign bus.busy        = busy_reg;
  assign bus.done        = done_reg;
  assign bus.div_by_zero = div_by_zero_reg;
  assign bus.overflow    = overflow_reg;

endmodule

// File: tb/tb_sequential_divider.sv
// tb_sequential_divider: scoreboard bench for sequential_divider (WIDTH=32).
// Expected results are pushed when an operation is started and popped when
// done is observed; latency, handshake, reset abort and hold are also checked.
module tb_sequential_divider;

  localparam int W = 32;

  typedef struct packed {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dbz;
    logic         ovf;
  } exp_t;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  int   op_num;
  exp_t sb[$];
  exp_t mon_e;

  sequential_divider_if #(.WIDTH(W)) bus ();

  sequential_divider #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference model: truncating signed division in 64-bit arithmetic, with the
  // two special cases handled explicitly.
  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t   e;
    longint sa;
    longint sb_v;
    e = '0;
    if (b == '0) begin
      e.q   = '1;
      e.r   = a;
      e.dbz = 1'b1;
    end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      e.q   = 32'h8000_0000;
      e.r   = '0;
      e.ovf = 1'b1;
    end else begin
      sa   = longint'($signed(a));
      sb_v = longint'($signed(b));
      e.q  = W'(sa / sb_v);
      e.r  = W'(sa % sb_v);
    end
    return e;
  endfunction

  // Completion monitor: every done must match the oldest pending expectation.
  always @(negedge clk) begin
    if (!rst && bus.done) begin
      if (sb.size() == 0) begin
        check("spurious_done", 64'(bus.done), 64'd0);
      end else begin
        mon_e = sb.pop_front();
        op_num++;
        $display("op %0d: quotient=%h remainder=%h dbz=%0b ovf=%0b (expected %h %h %0b %0b)",
                 op_num, bus.quotient, bus.remainder, bus.div_by_zero, bus.overflow,
                 mon_e.q, mon_e.r, mon_e.dbz, mon_e.ovf);
        check("quotient",    64'(bus.quotient),    64'(mon_e.q));
        check("remainder",   64'(bus.remainder),   64'(mon_e.r));
        check("div_by_zero", 64'(bus.div_by_zero), 64'(mon_e.dbz));
        check("overflow",    64'(bus.overflow),    64'(mon_e.ovf));
        check("busy_at_done", 64'(bus.busy),       64'd0);
      end
    end
  end

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b);
    sb.push_back(model(a, b));
    bus.start = 1'b1;
    bus.in1   = a;
    bus.in2   = b;
    @(negedge clk);
    bus.start = 1'b0;
    bus.in1   = $urandom;
    bus.in2   = $urandom;
    check("busy_after_start", 64'(bus.busy), 64'd1);
  endtask

  // Counts edges after the accepting edge until done is seen (bounded).
  task automatic wait_done(input int already, input int lat);
    int edges;
    edges = already;
    do begin
      @(negedge clk);
      edges++;
    end while (!bus.done && edges < already + 100);
    check("latency", 64'(edges), 64'(lat));
  endtask

  task automatic run(input logic [W-1:0] a, input logic [W-1:0] b, input int lat);
    start_op(a, b);
    wait_done(0, lat);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    checks    = 0;
    errors    = 0;
    op_num    = 0;
    rst       = 1'b1;
    bus.start = 1'b0;
    bus.in1   = '0;
    bus.in2   = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", 64'(bus.busy), 64'd0);
    check("rst_done", 64'(bus.done), 64'd0);
    check("rst_quotient", 64'(bus.quotient), 64'd0);
    check("rst_remainder", 64'(bus.remainder), 64'd0);
    check("rst_flags", 64'({bus.div_by_zero, bus.overflow}), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    run(32'd100, 32'd7, 33);
    run(-32'd100, 32'd7, 33);
    run(32'd100, -32'd7, 33);
    run(-32'd100, -32'd7, 33);
    run(32'h8000_0000, 32'hFFFF_FFFF, 33);
    run(32'h8000_0000, 32'd1, 33);
    run(32'd55, 32'd0, 1);
    run(32'd9, 32'd3, 33);

    // Results hold after the done pulse.
    repeat (5) @(negedge clk);
    check("hold_quotient", 64'(bus.quotient), 64'd3);
    check("hold_done", 64'(bus.done), 64'd0);

    run(32'd0, 32'd12345, 33);

    // A start while busy is ignored.
    start_op(32'd1000, 32'd10);
    repeat (9) @(negedge clk);
    bus.start = 1'b1;
    bus.in1   = 32'd5;
    bus.in2   = 32'd5;
    @(negedge clk);
    bus.start = 1'b0;
    wait_done(10, 33);
    // A start in the done cycle is accepted.
    start_op(32'd5, 32'd5);
    wait_done(0, 33);

    // Reset in the middle of an operation aborts it with no done pulse.
    start_op(32'd7, 32'd2);
    repeat (14) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    sb.delete();
    check("abort_busy", 64'(bus.busy), 64'd0);
    check("abort_done", 64'(bus.done), 64'd0);
    check("abort_quotient", 64'(bus.quotient), 64'd0);
    check("abort_remainder", 64'(bus.remainder), 64'd0);
    check("abort_flags", 64'({bus.div_by_zero, bus.overflow}), 64'd0);
    repeat (40) @(negedge clk);
    run(32'd7, 32'd2, 33);

    for (int i = 0; i < 6; i++) begin
      ra = $urandom;
      rb = W'($urandom_range(1, 1000));
      if ($urandom_range(0, 1) == 1) rb = -rb;
      run(ra, rb, 33);
    end

    repeat (3) @(negedge clk);
    check("scoreboard_empty", 64'(sb.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
